// File: rtl/mem_arbiter.sv
// Arbitrates the single-port memory between instruction fetch (I) and load/store (D).
// Default: fixed priority D over I with a starvation guard; define ARB_MEM_RR_EN for round-robin.
module mem_arbiter #(
   parameter int STARVE_MAX = 4,
   parameter int CNT_W      = 3
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_gnt,
   output logic        i_rvalid,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wmask,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        m_strb,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_wmask,
   input  logic [31:0] m_rdata
);

   logic gnt_i;
   logic gnt_d;
   logic rsp_i;
   logic rsp_d;
   logic d_store;

`ifdef ARB_MEM_RR_EN
   logic last_d;

   always_comb begin
      gnt_i = 1'b0;
      gnt_d = 1'b0;
      if (rstn) begin
         if (i_req && d_req) begin
            gnt_i = last_d;
            gnt_d = !last_d;
         end else begin
            gnt_i = i_req;
            gnt_d = d_req;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         last_d <= 1'b0;
      end else if (gnt_i) begin
         last_d <= 1'b0;
      end else if (gnt_d) begin
         last_d <= 1'b1;
      end
   end
`else
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0] starve_cnt;
   logic             starved;

   assign starved = (starve_cnt == STARVE_LIM);

   always_comb begin
      gnt_i = 1'b0;
      gnt_d = 1'b0;
      if (rstn) begin
         if (i_req && d_req) begin
            gnt_i = starved;
            gnt_d = !starved;
         end else begin
            gnt_i = i_req;
            gnt_d = d_req;
         end
      end
   end

   // Counts consecutive lost cycles for I, saturating at the limit.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         starve_cnt <= '0;
      end else if (gnt_i) begin
         starve_cnt <= '0;
      end else if (i_req && !starved) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end
`endif

   assign d_store = (d_wmask != 4'b0000);

   assign i_gnt   = gnt_i;
   assign d_gnt   = gnt_d;
   assign m_strb  = gnt_i | (gnt_d & !d_store);
   assign m_addr  = gnt_i ? i_addr : d_addr;
   assign m_wdata = d_wdata;
   assign m_wmask = gnt_d ? d_wmask : 4'b0000;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         rsp_i <= 1'b0;
         rsp_d <= 1'b0;
      end else begin
         rsp_i <= gnt_i;
         rsp_d <= gnt_d;
      end
   end

   // A response registered just before reset asserts must not surface during reset.
   assign i_rvalid = rsp_i & rstn;
   assign d_rvalid = rsp_d & rstn;
   assign i_rdata  = m_rdata;
   assign d_rdata  = m_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random traffic,
// compared cycle by cycle against a transaction-level reference model and a behavioural memory.
module tb_mem_arbiter;

   localparam int STARVE_MAX = 4;
   localparam int CNT_W      = 3;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        i_req = 1'b0;
   logic [31:0] i_addr = '0;
   logic        i_gnt;
   logic        i_rvalid;
   logic [31:0] i_rdata;
   logic        d_req = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic [3:0]  d_wmask = '0;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        m_strb;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [3:0]  m_wmask;
   logic [31:0] m_rdata = '0;

   mem_arbiter #(.STARVE_MAX(STARVE_MAX), .CNT_W(CNT_W)) dut (
      .clk(clk), .rstn(rstn),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_strb(m_strb), .m_addr(m_addr), .m_wdata(m_wdata), .m_wmask(m_wmask), .m_rdata(m_rdata)
   );

   always #5 clk = ~clk;

   // Behavioural memory: 64 words, registered read, byte lane k written from d_wdata[8k+7:8k].
   logic [31:0] mem [64];
   initial begin
      for (int k = 0; k < 64; k++) mem[k] = 32'hC0DE_0000 | k;
      forever begin
         @(posedge clk);
         if (m_strb) m_rdata <= mem[m_addr[7:2]];
         for (int b = 0; b < 4; b++)
            if (m_wmask[b]) mem[m_addr[7:2]][8*b +: 8] <= m_wdata[8*b +: 8];
      end
   end

   // Reference model state (transaction level).
   logic [31:0] ref_mem [64];
   int          i_losses;
   logic        last_was_d;
   logic        p_i, p_d, p_store;
   logic [31:0] p_data;
   logic        eg_i, eg_d;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step(input logic rst_v, input logic ir, input logic [31:0] ia,
                       input logic dr, input logic [31:0] da, input logic [31:0] dw,
                       input logic [3:0] dm);
      @(posedge clk); #1;
      rstn = rst_v; i_req = ir; i_addr = ia;
      d_req = dr; d_addr = da; d_wdata = dw; d_wmask = dm;
      @(negedge clk);
      eg_i = 1'b0;
      eg_d = 1'b0;
      if (rst_v) begin
         if (ir && dr) begin
`ifdef ARB_MEM_RR_EN
            if (last_was_d) eg_i = 1'b1; else eg_d = 1'b1;
`else
            if (i_losses >= STARVE_MAX) eg_i = 1'b1; else eg_d = 1'b1;
`endif
         end else begin
            eg_i = ir;
            eg_d = dr;
         end
      end
      chk("i_gnt", {31'b0, i_gnt}, {31'b0, eg_i});
      chk("d_gnt", {31'b0, d_gnt}, {31'b0, eg_d});
      chk("m_strb", {31'b0, m_strb}, {31'b0, eg_i || (eg_d && dm == 4'b0)});
      chk("m_wmask", {28'b0, m_wmask}, {28'b0, (eg_d ? dm : 4'b0)});
      if (eg_i) chk("m_addr_i", m_addr, ia);
      else if (eg_d) chk("m_addr_d", m_addr, da);
      if (eg_d && dm != 4'b0) chk("m_wdata", m_wdata, dw);
      chk("i_rvalid", {31'b0, i_rvalid}, {31'b0, rst_v && p_i});
      chk("d_rvalid", {31'b0, d_rvalid}, {31'b0, rst_v && p_d});
      if (rst_v && p_i) chk("i_rdata", i_rdata, p_data);
      if (rst_v && p_d && !p_store) chk("d_rdata", d_rdata, p_data);
      if (!rst_v) begin
         p_i = 1'b0; p_d = 1'b0; p_store = 1'b0;
         i_losses = 0; last_was_d = 1'b0;
      end else begin
         p_i = eg_i;
         p_d = eg_d;
         p_store = eg_d && dm != 4'b0;
         if (eg_i) p_data = ref_mem[ia[7:2]];
         else if (eg_d) p_data = ref_mem[da[7:2]];
         if (p_store)
            for (int b = 0; b < 4; b++)
               if (dm[b]) ref_mem[da[7:2]][8*b +: 8] = dw[8*b +: 8];
         if (eg_i) i_losses = 0;
         else if (ir) i_losses = (i_losses + 1 > STARVE_MAX) ? STARVE_MAX : i_losses + 1;
         if (eg_i) last_was_d = 1'b0;
         else if (eg_d) last_was_d = 1'b1;
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b1, 1'b0, '0, 1'b0, '0, '0, 4'b0);
   endtask

   logic        cur_ir, cur_dr, cur_rst;
   logic [31:0] cur_ia, cur_da, cur_dw;
   logic [3:0]  cur_dm;
   logic        held_i, held_d;

   initial begin
      for (int k = 0; k < 64; k++) ref_mem[k] = 32'hC0DE_0000 | k;
      i_losses = 0; last_was_d = 1'b0;
      p_i = 1'b0; p_d = 1'b0; p_store = 1'b0; p_data = '0;
      eg_i = 1'b0; eg_d = 1'b0;

      // Reset with both requesting: no grants, no strobes.
      step(1'b0, 1'b1, 32'h10, 1'b1, 32'h20, 32'h0, 4'b0);
      step(1'b0, 1'b0, '0, 1'b0, '0, '0, 4'b0);

      // 1: fetch words 4,5,6 back to back.
      for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 32'h10 + 4*k, 1'b0, '0, '0, 4'b0);
      idle(1);

      // 2: byte store then load of the same word.
      step(1'b1, 1'b0, '0, 1'b1, 32'h20, 32'h0000_00AB, 4'b0001);
      step(1'b1, 1'b0, '0, 1'b1, 32'h20, 32'h0, 4'b0000);
      idle(1);

      // 3: both held; I wins only after losing STARVE_MAX times, then the cycle repeats.
      for (int k = 0; k < 2 * (STARVE_MAX + 1) + 1; k++)
         step(1'b1, 1'b1, 32'h40, 1'b1, 32'h44, 32'h0, 4'b0);
      idle(1);

      // 5: reset asserted the cycle after a grant drops the response.
      step(1'b1, 1'b1, 32'h08, 1'b0, '0, '0, 4'b0);
      step(1'b0, 1'b1, 32'h0C, 1'b1, 32'h30, 32'h1234_5678, 4'b1111);
      step(1'b1, 1'b1, 32'h0C, 1'b0, '0, '0, 4'b0);
      idle(1);

      // 6: fetch then store in consecutive cycles; rvalids never overlap.
      step(1'b1, 1'b1, 32'h14, 1'b0, '0, '0, 4'b0);
      step(1'b1, 1'b0, '0, 1'b1, 32'h14, 32'hDEAD_BEEF, 4'b1100);
      step(1'b1, 1'b1, 32'h14, 1'b0, '0, '0, 4'b0);
      idle(1);

      // Random traffic honouring the hold-until-grant handshake.
      held_i = 1'b0; held_d = 1'b0;
      cur_ir = 1'b0; cur_dr = 1'b0; cur_ia = '0; cur_da = '0; cur_dw = '0; cur_dm = '0;
      for (int n = 0; n < 1500; n++) begin
         if (!held_i) begin
            cur_ir = ($urandom_range(0, 2) != 0);
            cur_ia = {24'b0, 8'($urandom_range(0, 255))};
         end
         if (!held_d) begin
            cur_dr = ($urandom_range(0, 3) != 0);
            cur_da = {$urandom_range(0, 255) > 250 ? 24'hFFFFFF : 24'h0, 8'($urandom_range(0, 255))};
            cur_dw = $urandom;
            cur_dm = ($urandom_range(0, 1) == 0) ? 4'b0 : 4'($urandom_range(1, 15));
         end
         cur_rst = ($urandom_range(0, 80) != 0);
         step(cur_rst, cur_ir, cur_ia, cur_dr, cur_da, cur_dw, cur_dm);
         held_i = cur_ir && !eg_i;
         held_d = cur_dr && !eg_d;
      end
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
